// File: rtl/rls803_if.sv
// rls803_if: operand, control and result signals of the rls803 shift stage.
// With RLS803_CARRY_EN defined the bundle also carries the registered carry_out bit.
interface rls803_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amount;
    logic             direction;
    logic [WIDTH-1:0] data_out;
`ifdef RLS803_CARRY_EN
    logic             carry_out;
`endif

    // The datapath side drives operands and controls and observes the result.
    modport master (
        output data_in,
        output shift_amount,
        output direction,
`ifdef RLS803_CARRY_EN
        input  carry_out,
`endif
        input  data_out
    );

    // The shift register receives operands and controls and drives the result.
    modport slave (
        input  data_in,
        input  shift_amount,
        input  direction,
`ifdef RLS803_CARRY_EN
        output carry_out,
`endif
        output data_out
    );
endinterface

// File: rtl/rls803.sv
// rls803: clocked load/shift register, the barrel-shift stage of the WIMS datapath.
// After a clear the register is armed: the next edge with shift_amount=0 loads data_in.
// Any edge with shift_amount!=0 shifts the held value logically by 0..WIDTH-1 places.
// Optional build macro RLS803_CARRY_EN adds a registered carry_out holding the last bit
// shifted out.
module rls803 #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic      clk,
    input logic      clear,
    rls803_if.slave  bus
);

    logic [WIDTH-1:0] r;
    logic             armed;
    logic [WIDTH-1:0] shifted;

`ifdef RLS803_CARRY_EN
    logic             carry;
    logic             shift_carry;
    logic [WIDTH:0]   right_ext;
    logic [WIDTH:0]   left_ext;

    // Log-depth shifter on vectors widened by one guard bit, so that after the final stage
    // the guard bit holds the last bit pushed off the end.
    always_comb begin
        right_ext = {r, 1'b0};
        left_ext  = {1'b0, r};
        for (int s = 0; s < SHW; s++) begin
            if (bus.shift_amount[s]) begin
                right_ext = right_ext >> (1 << s);
                left_ext  = left_ext  << (1 << s);
            end
        end
    end

    assign shifted     = bus.direction ? left_ext[WIDTH-1:0] : right_ext[WIDTH:1];
    assign shift_carry = bus.direction ? left_ext[WIDTH]     : right_ext[0];
    assign bus.carry_out = carry;
`else
    logic [WIDTH-1:0] right_val;
    logic [WIDTH-1:0] left_val;

    // Log-depth shifter: one conditional power-of-two stage per shift_amount bit.
    always_comb begin
        right_val = r;
        left_val  = r;
        for (int s = 0; s < SHW; s++) begin
            if (bus.shift_amount[s]) begin
                right_val = right_val >> (1 << s);
                left_val  = left_val  << (1 << s);
            end
        end
    end

    assign shifted = bus.direction ? left_val : right_val;
`endif

    // Register update: clear wins, then load or hold when shift_amount is zero, else shift.
    always_ff @(posedge clk) begin
        if (clear) begin
            r     <= '0;
            armed <= 1'b1;
`ifdef RLS803_CARRY_EN
            carry <= 1'b0;
`endif
        end else if (bus.shift_amount == '0) begin
            if (armed) begin
                r     <= bus.data_in;
                armed <= 1'b0;
            end
`ifdef RLS803_CARRY_EN
            carry <= 1'b0;
`endif
        end else begin
            r     <= shifted;
            armed <= 1'b0;
`ifdef RLS803_CARRY_EN
            carry <= shift_carry;
`endif
        end
    end

    assign bus.data_out = r;

endmodule

// File: tb/tb_rls803.sv
// tb_rls803: directed vector table for rls803 followed by random traffic checked against
// an arithmetic model of the load/hold/shift rules. Follows RLS803_CARRY_EN if defined.
module tb_rls803;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic clk;
    logic clear;

    rls803_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    rls803 #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic       clr;
        logic [7:0] din;
        logic [2:0] amt;
        logic       dir;
        logic [7:0] exp_out;
        logic       exp_carry;
        string      name;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned model_r     = 0;
    bit          model_armed = 1'b0;
    bit          model_carry = 1'b0;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour written directly from the load/hold/shift rules.
    task automatic model_step(input bit c, input int unsigned din, input int unsigned amt,
                              input bit dir);
        int unsigned mask = (1 << WIDTH) - 1;
        if (c) begin
            model_r     = 0;
            model_armed = 1'b1;
            model_carry = 1'b0;
        end else if (amt == 0) begin
            if (model_armed) begin
                model_r     = din & mask;
                model_armed = 1'b0;
            end
            model_carry = 1'b0;
        end else begin
            if (dir) begin
                model_carry = ((model_r >> (WIDTH - amt)) & 1) != 0;
                model_r     = (model_r << amt) & mask;
            end else begin
                model_carry = ((model_r >> (amt - 1)) & 1) != 0;
                model_r     = model_r >> amt;
            end
            model_armed = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, let the DUT take the edge, and advance the model.
    task automatic applyStimulus(input bit c, input logic [7:0] din, input logic [2:0] amt,
                                 input bit dir);
        clear            = c;
        bus.data_in      = din;
        bus.shift_amount = amt;
        bus.direction    = dir;
        @(posedge clk);
        model_step(c, int'(din), int'(amt), dir);
        @(negedge clk);
    endtask

    // Compare the registered outputs against the expected values.
    task automatic checkOutput(input string name, input logic [7:0] exp_out,
                               input logic exp_carry);
        n_checks++;
        if (bus.data_out !== exp_out) begin
            n_fail++;
            $display("[TB] FAIL %s data_out: got %02h expected %02h", name, bus.data_out, exp_out);
        end
`ifdef RLS803_CARRY_EN
        n_checks++;
        if (bus.carry_out !== exp_carry) begin
            n_fail++;
            $display("[TB] FAIL %s carry_out: got %b expected %b", name, bus.carry_out, exp_carry);
        end
`else
        if (exp_carry === 1'bx) $display("[TB] note: unknown carry expectation for %s", name);
`endif
    endtask

    // Directed vectors, then randomised traffic against the model.
    initial begin
        clear            = 1'b0;
        bus.data_in      = '0;
        bus.shift_amount = '0;
        bus.direction    = 1'b0;

        vecs.push_back('{1'b1, 8'hFF, 3'd0, 1'b0, 8'h00, 1'b0, "clear"});
        vecs.push_back('{1'b0, 8'hAA, 3'd0, 1'b0, 8'hAA, 1'b0, "load_aa"});
        vecs.push_back('{1'b0, 8'hAA, 3'd2, 1'b0, 8'h2A, 1'b1, "rshift2"});
        vecs.push_back('{1'b0, 8'hAA, 3'd3, 1'b1, 8'h50, 1'b1, "lshift3"});
        vecs.push_back('{1'b0, 8'hAA, 3'd0, 1'b0, 8'h50, 1'b0, "hold"});
        vecs.push_back('{1'b1, 8'hAA, 3'd0, 1'b0, 8'h00, 1'b0, "clear2"});
        vecs.push_back('{1'b0, 8'hAA, 3'd0, 1'b0, 8'hAA, 1'b0, "reload_aa"});
        vecs.push_back('{1'b1, 8'h55, 3'd5, 1'b1, 8'h00, 1'b0, "clear_over_shift"});
        vecs.push_back('{1'b0, 8'h81, 3'd0, 1'b1, 8'h81, 1'b0, "load_81_dir1"});
        vecs.push_back('{1'b0, 8'hFF, 3'd7, 1'b0, 8'h01, 1'b0, "rshift7"});
        vecs.push_back('{1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, "clear3"});
        vecs.push_back('{1'b0, 8'h81, 3'd0, 1'b0, 8'h81, 1'b0, "reload_81"});
        vecs.push_back('{1'b0, 8'h00, 3'd7, 1'b1, 8'h80, 1'b0, "lshift7"});
        vecs.push_back('{1'b0, 8'h00, 3'd1, 1'b1, 8'h00, 1'b1, "lshift1_carry"});
        vecs.push_back('{1'b1, 8'hFF, 3'd7, 1'b1, 8'h00, 1'b0, "clear_held_a"});
        vecs.push_back('{1'b1, 8'hFF, 3'd7, 1'b1, 8'h00, 1'b0, "clear_held_b"});
        vecs.push_back('{1'b0, 8'hFF, 3'd3, 1'b1, 8'h00, 1'b0, "shift_while_armed"});
        vecs.push_back('{1'b0, 8'h77, 3'd0, 1'b0, 8'h00, 1'b0, "hold_after_disarm"});
        vecs.push_back('{1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, "clear4"});
        vecs.push_back('{1'b0, 8'h3C, 3'd0, 1'b0, 8'h3C, 1'b0, "load_3c"});
        vecs.push_back('{1'b0, 8'h00, 3'd1, 1'b0, 8'h1E, 1'b0, "rshift1"});
        vecs.push_back('{1'b0, 8'h00, 3'd4, 1'b1, 8'hE0, 1'b1, "lshift4"});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].din, vecs[i].amt, vecs[i].dir);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_carry);
        end

        for (int i = 0; i < 400; i++) begin
            bit          c;
            logic [7:0]  din;
            logic [2:0]  amt;
            bit          dir;
            c   = ($urandom_range(0, 15) == 0);
            din = 8'($urandom);
            amt = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            dir = 1'($urandom);
            applyStimulus(c, din, amt, dir);
            checkOutput("random", 8'(model_r), model_carry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rls803.md
Name: rls803

Overview:
- Clocked 8-bit load/shift register used as the barrel-shift stage of the WIMS datapath.
- It captures an operand from data_in, then shifts its held value logically left or right by 0–7 positions per clock.
- The result is presented on a registered output.
- A synchronous clear empties the register and re-arms it, so the next edge loads a new operand.

Parameters:
- WIDTH, 8, data width in bits; must be at least 2.
- SHW, 3, width of shift_amount; must equal ceil(log2(WIDTH)).

Ports:
- clk  input  1  rising-edge clock; all state changes occur on this edge.
- clear  input  1  synchronous, active-high reset/clear; sampled on the clk rising edge.
- data_in  input  WIDTH  operand loaded into the register.
- shift_amount  input  SHW  shift distance, 0..WIDTH-1.
- direction  input  1  0 = logical right shift, 1 = logical left shift.
- data_out  output  WIDTH  register contents (registered, no combinational path from inputs).

Behaviour:
- State: data register R[WIDTH-1:0] and a 1-bit flag `armed`.
- data_out = R at all times.
- Reset/clear: on a rising edge with clear=1:
  - R <= 0, armed <= 1.
  - Clear has priority over every other input.
  - No initial value is guaranteed before the first clear.
- Rising edge with clear=0, decoded in this priority order:
  - Load: armed=1 and shift_amount=0 → R <= data_in, armed <= 0. direction is ignored.
  - Hold: armed=0 and shift_amount=0 → R unchanged. data_in and direction are ignored.
  - Right shift: shift_amount=n≠0, direction=0 → R <= R >> n, zero-filled from the MSB side; armed <= 0.
  - Left shift: shift_amount=n≠0, direction=1 → R <= R << n, zero-filled from the LSB side; armed <= 0.
- Shifts always operate on the current R, never on data_in.
  - A shift issued while armed=1 shifts the cleared value 0 and yields 0, then disarms.
- Latency: one clock from input sampling to data_out update.
- Bits shifted past either end are discarded.
- Maximum shift is WIDTH-1: a shift of 7 leaves at most one surviving bit.
- Reset mid-operation: clear asserted in any cycle overrides any shift or load in that cycle. The following clear=0 edge with shift_amount=0 loads data_in.
- Clear held high for several cycles keeps R=0 and armed=1.
- The shifter is combinational (a mux tree over SHW stages) feeding the register; no multi-cycle shifting.

Optional Feature:
- Macro RLS803_CARRY_EN.
- When defined:
  - Adds output port carry_out (1 bit, registered).
  - On a shift edge, carry_out <= the last bit shifted out: R[n-1] for a right shift, R[WIDTH-n] for a left shift.
  - On load, hold or clear, carry_out <= 0.
- When undefined:
  - The port and its logic are absent.
  - Behaviour of data_out is identical in both builds.

Test Plan:
- Clear: data_in=8'hFF, shift_amount=0, direction=0, clear=1, one rising edge → data_out=8'b00000000.
- Load after clear: clear=0, data_in=8'b10101010, shift_amount=0, one edge → data_out=8'b10101010.
- Right shift: then shift_amount=2, direction=0, one edge → data_out=8'b00101010.
- Left shift: then shift_amount=3, direction=1, one edge → data_out=8'b01010000.
- Hold: then shift_amount=0, direction=0, data_in=8'b10101010, one edge → data_out stays 8'b01010000. Then clear=1, one edge → 0; then clear=0 with shift_amount=0 → reloads 8'b10101010.
- Extremes and carry: load 8'b10000001, then shift_amount=7 direction=0 → 8'b00000001. Reload (via clear) and shift_amount=7 direction=1 → 8'b10000000. With RLS803_CARRY_EN defined, after the right-shift-by-7 edge carry_out=0 (R[6] of 8'b10000001), and after a left shift by 1 of 8'b10000000 carry_out=1.
